mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit for the MIPS execute stage. It handles MULT, MULTU, DIV and DIVU through one start/busy/done handshake, and returns a 2×WIDTH {hi, lo} result that the pipeline writes into HI/LO. It supersedes the combinational multiplier and the external divider in the ALU. The pipeline stalls while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width. Must be even and ≥ 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled in IDLE or DONE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend. Sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor. Sampled with `start`.
- `cancel`  in  1  abort the in-flight op (exception/flush).
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  single-cycle pulse; results are valid from this cycle.
- `hi`  out  WIDTH  product high half, or remainder.
- `lo`  out  WIDTH  product low half, or quotient.
- `div_by_zero`  out  1  set on DIV/DIVU with b==0; held alongside the result.

## Operation
- **Reset:** state IDLE. `busy`, `done`, `div_by_zero` = 0. `hi`, `lo` = 0. Iteration counter = 0.
- **States:** IDLE, CALC, FIX, DONE.
  - IDLE→CALC on `start & ~cancel`.
  - IDLE→DONE on `start & ~cancel` for a divide with b==0.
  - CALC→FIX when the counter reaches WIDTH-1.
  - FIX→DONE unconditionally.
  - DONE→IDLE, or DONE→CALC/DONE if a new `start` is present in that cycle.
- **Accept:** latch op and operands. For signed ops, convert each operand to its magnitude (two's-complement negate if the MSB is set). Record neg_res = a[W-1]^b[W-1] and neg_rem = a[W-1]. Clear the counter.
- **CALC, multiply:** radix-2 shift-add. One multiplier bit is consumed per cycle into a 2W accumulator. Exactly WIDTH cycles.
- **CALC, divide:** restoring division. One quotient bit per cycle. The partial remainder is W+1 bits wide. Exactly WIDTH cycles.
- **FIX:**
  - Signed multiply: negate the 2W product if neg_res.
  - Signed divide: negate the quotient if neg_res; negate the remainder if neg_rem.
  - Unsigned ops: no correction.
- **Result mapping:**
  - Multiply: {hi,lo} = product.
  - Divide: lo = quotient, hi = remainder.
  - `hi`/`lo` change only on entry to DONE and hold until the next DONE.
- **Divide by zero:**
  - lo = all ones, hi = a (raw dividend, uncorrected), `div_by_zero` = 1.
  - No CALC or FIX; DONE is reached in the cycle after accept.
  - `div_by_zero` clears on the next accept.
- **Signed overflow:** DIV of −2^(W−1) by −1 gives lo = −2^(W−1), hi = 0, with no flag. This falls out naturally from the magnitude algorithm.
- **Start while busy:** ignored; there is no queueing.
- **Cancel:**
  - In CALC or FIX: → IDLE next cycle. No `done`; `hi`/`lo` keep their previous values.
  - In IDLE or DONE: any `start` in the same cycle is ignored.
- **`rst` mid-operation:** immediate return to the reset state. The result is lost.

## Timing
- Accept edge at cycle t (`start`=1 in IDLE/DONE).
- CALC occupies t+1 … t+WIDTH.
- FIX occupies t+WIDTH+1.
- DONE occupies t+WIDTH+2, with `done`=1. This is cycle t+34 for WIDTH=32.
- Divide by zero: DONE at t+1.
- `busy` is high for WIDTH+1 cycles, low in DONE.
- Back-to-back: a `start` in the DONE cycle is accepted, giving one op per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst` 2 cycles mid-CALC → `busy`=0, `done`=0, hi=lo=0. A following MULTU 3×5 → lo=0x0000000F, hi=0, `done` at t+34.
- **Signed multiply:** MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. `done` exactly at t+34; `busy` high t+1…t+33.
- **Unsigned multiply, max operands:** MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- **Signed divide:**
  - DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- **Divide by zero:** DIVU 100/0 → `done` at t+1, lo=0xFFFFFFFF, hi=0x00000064, `div_by_zero`=1. The next DIVU 9/4 clears the flag and gives lo=2, hi=1.
- **Cancel and ignored start:**
  - `cancel` at t+10 of a MULT → IDLE at t+11, no `done`, prior hi/lo unchanged.
  - `start` pulses during `busy` are ignored.
  - `start` in the DONE cycle is accepted, and its `done` arrives 34 cycles later.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
// It uses radix-2 shift-add and restoring division, with a sign fix-up cycle before DONE.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]         state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               is_div, neg_res, neg_rem;
   logic [WIDTH-1:0]   acc_hi, acc_lo, mcand;

   logic               accept, dbz_req;
   logic [WIDTH:0]     add_sum, div_shift, div_trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
      return en ? -x : x;
   endfunction

   assign accept  = start && !cancel && (state == S_IDLE || state == S_DONE);
   assign dbz_req = op[1] && (b == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) state_nxt = dbz_req ? S_DONE : S_CALC;
            else        state_nxt = S_IDLE;
         end
         S_CALC: begin
            if (cancel)               state_nxt = S_IDLE;
            else if (cnt == CNT_LAST) state_nxt = S_FIX;
         end
         default: state_nxt = cancel ? S_IDLE : S_DONE;
      endcase
   end

   // One iteration step: the shift-add for multiply, or the restoring trial subtract for divide.
   always_comb begin
      add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, mcand};
   end

   // Sign fix-up applied in the FIX cycle; neg_res/neg_rem are already zero for unsigned ops.
   always_comb begin
      prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quot_fix = neg_if(acc_lo, neg_res);
      rem_fix  = neg_if(acc_hi, neg_rem);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == S_CALC) || (state_nxt == S_FIX);
         done  <= (state_nxt == S_DONE);
         if (accept) begin
            cnt         <= '0;
            div_by_zero <= dbz_req;
            if (dbz_req) begin
               hi <= a;
               lo <= '1;
            end
         end else if (state == S_CALC) begin
            cnt <= cnt + 1'b1;
         end else if (state == S_FIX && !cancel) begin
            if (is_div) begin
               hi <= rem_fix;
               lo <= quot_fix;
            end else begin
               {hi, lo} <= prod_fix;
            end
         end
      end
   end

   // Datapath registers carry no reset; they are always reloaded on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         is_div  <= op[1];
         neg_res <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_rem <= !op[0] && a[WIDTH-1];
         acc_hi  <= '0;
         if (op[1]) begin
            acc_lo <= magnitude(a, !op[0]);
            mcand  <= magnitude(b, !op[0]);
         end else begin
            acc_lo <= magnitude(b, !op[0]);
            mcand  <= magnitude(a, !op[0]);
         end
      end else if (state == S_CALC) begin
         if (is_div) begin
            if (!div_trial[WIDTH]) begin
               acc_hi <= div_trial[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
               acc_hi <= div_shift[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_hi <= add_sum[WIDTH:1];
            acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and random bench for mdu_iter, with a scoreboard of {div_by_zero, hi, lo}.
// The expected values come from a reference model that uses 64-bit arithmetic.
module tb_mdu_iter;

   localparam int W = 32;
   localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

   logic         clk = 1'b0;
   logic         rst, start, cancel;
   logic [1:0]   op;
   logic [W-1:0] a, b, hi, lo;
   logic         busy, done, div_by_zero;

   int           n_assert = 0;
   int           n_fail = 0;
   logic [2*W:0] sb[$];

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [63:0] p, q, r;
      longint      sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == OP_MULT) begin
         p = sx * sy;
         return {1'b0, p};
      end else if (o == OP_MULTU) begin
         p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
         return {1'b0, p};
      end else if (y == '0) begin
         return {1'b1, x, {W{1'b1}}};
      end else if (o == OP_DIV) begin
         q = sx / sy;
         r = sx % sy;
      end else begin
         q = {{W{1'b0}}, x / y};
         r = {{W{1'b0}}, x % y};
      end
      return {1'b0, r[W-1:0], q[W-1:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      if (push) sb.push_back(model(o, x, y));
   endtask

   // Called right after issue(); it ends on the negedge where done is high.
   task automatic wait_done(input int exp_lat, input string tag, input int pulse_at);
      int           n;
      int           busy_bad;
      bit           seen;
      logic [2*W:0] e;
      n = 0;
      busy_bad = 0;
      seen = 0;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (pulse_at != 0 && n == pulse_at) begin
            start = 1'b1; op = OP_DIVU; a = 1; b = 0;
         end
         if (pulse_at != 0 && n == pulse_at + 1) start = 1'b0;
         if (done === 1'b1) seen = 1;
         else if (busy !== 1'b1) busy_bad++;
      end
      chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
      chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
      chk({tag, "_busy_done"}, 64'(busy), 64'd0);
      if (seen && sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
         chk({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
         chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e[2*W]));
      end
   endtask

   initial begin
      int           cnt_done;
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      logic [2*W:0] prev;

      rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);
      rst = 1'b0;

      // Reset in the middle of a calculation
      @(negedge clk);
      issue(OP_MULTU, 7, 9, 0);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_busy_before_rst", 64'(busy), 64'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_hilo", {hi, lo}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      issue(OP_MULTU, 3, 5, 1);
      wait_done(34, "multu_3x5", 0);
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd0);
      chk("hold_lo", 64'(lo), 64'hF);

      issue(OP_MULT, 32'hFFFF_FFFD, 7, 1);
      wait_done(34, "mult_neg", 0);
      @(negedge clk);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      wait_done(34, "multu_max", 0);
      @(negedge clk);
      issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1);
      wait_done(34, "mult_minmin", 0);
      @(negedge clk);
      issue(OP_DIV, 32'hFFFF_FFF9, 2, 1);
      wait_done(34, "div_m7_2", 0);
      @(negedge clk);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      wait_done(34, "div_ovf", 0);
      @(negedge clk);
      issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1);
      wait_done(34, "div_7_m2", 0);

      // Divide by zero and flag clearing
      @(negedge clk);
      issue(OP_DIVU, 100, 0, 1);
      wait_done(1, "divu_by0", 0);
      @(negedge clk);
      issue(OP_DIVU, 9, 4, 1);
      wait_done(34, "divu_9_4", 0);
      prev = model(OP_DIVU, 9, 4);
      @(negedge clk);
      issue(OP_DIV, 32'hFFFF_FFFB, 0, 1);
      wait_done(1, "div_by0_neg", 0);
      prev = model(OP_DIV, 32'hFFFF_FFFB, 0);

      // Cancel during CALC
      @(negedge clk);
      issue(OP_MULT, 123, 456, 0);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (n == 10) cancel = 1'b1;
      end
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", 64'(busy), 64'd0);
      chk("cancel_done", 64'(done), 64'd0);
      cnt_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) cnt_done++;
      end
      chk("cancel_no_done", 64'(cnt_done), 64'd0);
      chk("cancel_hold_hi", 64'(hi), 64'(prev[2*W-1:W]));
      chk("cancel_hold_lo", 64'(lo), 64'(prev[W-1:0]));

      // Cancel coincident with start in IDLE
      start = 1'b1; cancel = 1'b1; op = OP_MULTU; a = 2; b = 2;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("cancel_idle_busy", 64'(busy), 64'd0);
      chk("cancel_idle_done", 64'(done), 64'd0);

      // A start during busy is ignored
      @(negedge clk);
      issue(OP_MULTU, 6, 7, 1);
      wait_done(34, "busy_start", 5);
      cnt_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) cnt_done++;
      end
      chk("busy_start_ignored", 64'(cnt_done), 64'd0);

      // Back-to-back: a start in the DONE cycle
      issue(OP_DIV, 100, 32'hFFFF_FFF9, 1);
      wait_done(34, "b2b_first", 0);
      issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1);
      wait_done(34, "b2b_second", 0);
      issue(OP_DIVU, 32'hFFFF_FFFF, 0, 1);
      wait_done(1, "b2b_dbz", 0);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 5) ? '0 : $urandom;
         if (i == 3) rb = 32'($urandom_range(1, 9));
         issue(ro, ra, rb, 1);
         wait_done((ro[1] && rb == '0) ? 1 : 34, "rand", 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
